// File: rtl/mem_stage_sram_ctrl_if.sv
// Bundle of MEM-stage request/response signals and the 16-bit SRAM pin signals.
// The slave modport belongs to the controller; the master modport belongs to the pipeline/board side.
interface mem_stage_sram_ctrl_if;
  logic        MEM_R_en;
  logic        MEM_W_en;
  logic [31:0] ALU_result;
  logic [31:0] ST_value;
  logic [31:0] MEM_R_value;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic [15:0] sram_dq_in;

  modport slave (
    input  MEM_R_en, MEM_W_en, ALU_result, ST_value, sram_dq_in,
    output MEM_R_value, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output MEM_R_en, MEM_W_en, ALU_result, ST_value, sram_dq_in,
    input  MEM_R_value, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller that splits each 32-bit load/store into two 16-bit SRAM accesses.
// Each access stalls the pipeline until a single-cycle DONE state.
module mem_stage_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                   clk,
  input logic                   rst,
  mem_stage_sram_ctrl_if.slave  bus
);

  localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);
  // With zero wait cycles the single cycle of a phase is also its last, so no strobe is issued.
  localparam logic WeNFirst = (WAIT_CYCLES != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] r_value_q;
  logic [17:0] sram_addr_q;
  logic [15:0] sram_dq_out_q;
  logic        sram_dq_oe_q;
  logic        sram_we_n_q;

  logic        req;
  logic        is_store;
  logic        is_load;
  logic [31:0] offset;
  logic [16:0] word;
  logic        unused_offset;

  assign req      = bus.MEM_R_en | bus.MEM_W_en;
  assign is_store = bus.MEM_W_en;
  assign is_load  = bus.MEM_R_en & ~bus.MEM_W_en;
  assign offset   = bus.ALU_result - BASE_ADDR;
  assign word     = offset[18:2];
  assign unused_offset = ^{offset[31:19], offset[1:0]};

  assign bus.ready       = ((state_q == StIdle) && !req) || (state_q == StDone);
  assign bus.MEM_R_value = r_value_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = sram_dq_out_q;
  assign bus.sram_dq_oe  = sram_dq_oe_q;
  assign bus.sram_we_n   = sram_we_n_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= 3'd0;
      r_value_q     <= 32'd0;
      sram_addr_q   <= 18'd0;
      sram_dq_out_q <= 16'd0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            state_q       <= StLo;
            cnt_q         <= WaitInit;
            sram_addr_q   <= {word, 1'b0};
            sram_dq_out_q <= bus.ST_value[15:0];
            sram_dq_oe_q  <= is_store;
            sram_we_n_q   <= is_store ? WeNFirst : 1'b1;
          end
        end
        StLo: begin
          if (cnt_q == 3'd0) begin
            if (is_load) r_value_q[15:0] <= bus.sram_dq_in;
            state_q       <= StHi;
            cnt_q         <= WaitInit;
            sram_addr_q   <= {word, 1'b1};
            sram_dq_out_q <= bus.ST_value[31:16];
            sram_dq_oe_q  <= is_store;
            sram_we_n_q   <= is_store ? WeNFirst : 1'b1;
          end else begin
            cnt_q       <= cnt_q - 3'd1;
            // Release the strobe for the last cycle of the phase to hold address past write end.
            sram_we_n_q <= !(is_store && (cnt_q != 3'd1));
          end
        end
        StHi: begin
          if (cnt_q == 3'd0) begin
            if (is_load) r_value_q[31:16] <= bus.sram_dq_in;
            state_q      <= StDone;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
          end else begin
            cnt_q       <= cnt_q - 3'd1;
            sram_we_n_q <= !(is_store && (cnt_q != 3'd1));
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a 16-entry behavioural SRAM.
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] sram [16];

  mem_stage_sram_ctrl_if bus ();

  mem_stage_sram_ctrl #(
    .BASE_ADDR   (32'd1024),
    .WAIT_CYCLES (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.sram_dq_in = sram[bus.sram_addr[3:0]];

  // Writes are captured mid-cycle so the registered pin values are settled.
  task automatic tick();
    @(negedge clk);
    if (!bus.sram_we_n && bus.sram_dq_oe) sram[bus.sram_addr[3:0]] = bus.sram_dq_out;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.MEM_R_en   = r;
    bus.MEM_W_en   = w;
    bus.ALU_result = a;
    bus.ST_value   = d;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    n_tests++; if (bus.sram_we_n !== 1'b1) begin n_fail++;
      $display("FAIL rst_we_n got %b want 1", bus.sram_we_n); end
    n_tests++; if (bus.sram_dq_oe !== 1'b0) begin n_fail++;
      $display("FAIL rst_oe got %b want 0", bus.sram_dq_oe); end
    n_tests++; if (bus.sram_addr !== 18'd0) begin n_fail++;
      $display("FAIL rst_addr got %0d want 0", bus.sram_addr); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_tests++; if (bus.ready !== 1'b1) begin n_fail++;
      $display("FAIL idle_ready got %b want 1", bus.ready); end
    n_tests++; if (bus.MEM_R_value !== 32'd0) begin n_fail++;
      $display("FAIL idle_rvalue got %h want 0", bus.MEM_R_value); end
    n_tests++; if (bus.sram_we_n !== 1'b1) begin n_fail++;
      $display("FAIL idle_we_n got %b want 1", bus.sram_we_n); end
  endtask

  task automatic test_load();
    logic [17:0] exp_addr;
    sram[2] = 16'hBEEF;
    sram[3] = 16'hDEAD;
    drive(1'b1, 1'b0, 32'd1028, 32'd0);
    for (int c = 0; c < 5; c++) begin
      n_tests++; if (bus.ready !== 1'b0) begin n_fail++;
        $display("FAIL load_stall cycle %0d got ready %b want 0", c, bus.ready); end
      if (c > 0) begin
        exp_addr = (c < 3) ? 18'd2 : 18'd3;
        n_tests++; if (bus.sram_addr !== exp_addr) begin n_fail++;
          $display("FAIL load_addr cycle %0d got %0d want %0d", c, bus.sram_addr, exp_addr); end
        n_tests++; if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin n_fail++;
          $display("FAIL load_pins cycle %0d got we_n %b oe %b want 1 0", c, bus.sram_we_n,
                   bus.sram_dq_oe); end
      end
      tick();
    end
    n_tests++; if (bus.ready !== 1'b1) begin n_fail++;
      $display("FAIL load_done_ready got %b want 1", bus.ready); end
    n_tests++; if (bus.MEM_R_value !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL load_value got %h want deadbeef", bus.MEM_R_value); end
    drive(1'b0, 1'b0, 32'd1028, 32'd0);
    tick();
    n_tests++; if (bus.ready !== 1'b1) begin n_fail++;
      $display("FAIL load_after_ready got %b want 1", bus.ready); end
  endtask

  task automatic test_store();
    int low_cnt;
    int stall_cnt;
    sram[0] = 16'h0000;
    sram[1] = 16'h0000;
    low_cnt = 0;
    stall_cnt = 0;
    drive(1'b0, 1'b1, 32'd1024, 32'h12345678);
    for (int c = 0; c < 5; c++) begin
      if (bus.ready === 1'b0) stall_cnt++;
      if (bus.sram_we_n === 1'b0) low_cnt++;
      if (c == 1) begin
        n_tests++; if (bus.sram_dq_out !== 16'h5678 || bus.sram_dq_oe !== 1'b1) begin n_fail++;
          $display("FAIL store_lo_dq got %h oe %b want 5678 1", bus.sram_dq_out, bus.sram_dq_oe);
        end
      end
      if (c == 3) begin
        n_tests++; if (bus.sram_dq_out !== 16'h1234) begin n_fail++;
          $display("FAIL store_hi_dq got %h want 1234", bus.sram_dq_out); end
      end
      tick();
    end
    n_tests++; if (stall_cnt != 5) begin n_fail++;
      $display("FAIL store_stall got %0d want 5", stall_cnt); end
    n_tests++; if (low_cnt != 2) begin n_fail++;
      $display("FAIL store_we_low got %0d want 2", low_cnt); end
    n_tests++; if (bus.ready !== 1'b1) begin n_fail++;
      $display("FAIL store_done_ready got %b want 1", bus.ready); end
    n_tests++; if (sram[0] !== 16'h5678 || sram[1] !== 16'h1234) begin n_fail++;
      $display("FAIL store_data got %h %h want 5678 1234", sram[0], sram[1]); end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_both();
    drive(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    for (int c = 0; c < 5; c++) tick();
    n_tests++; if (sram[4] !== 16'hF00D || sram[5] !== 16'hCAFE) begin n_fail++;
      $display("FAIL both_store got %h %h want f00d cafe", sram[4], sram[5]); end
    n_tests++; if (bus.MEM_R_value !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL both_rvalue got %h want deadbeef", bus.MEM_R_value); end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 32'd1028, 32'd0);
    for (int c = 0; c < 5; c++) tick();
    n_tests++; if (bus.ready !== 1'b1 || bus.MEM_R_value !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL b2b_first got ready %b value %h want 1 deadbeef", bus.ready,
               bus.MEM_R_value); end
    tick();
    drive(1'b1, 1'b0, 32'd1032, 32'd0);
    n_tests++; if (bus.ready !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle_req got ready %b want 0", bus.ready); end
    tick();
    n_tests++; if (bus.sram_addr !== 18'd4) begin n_fail++;
      $display("FAIL b2b_addr got %0d want 4", bus.sram_addr); end
    for (int c = 0; c < 4; c++) tick();
    n_tests++; if (bus.ready !== 1'b1 || bus.MEM_R_value !== 32'hCAFEF00D) begin n_fail++;
      $display("FAIL b2b_second got ready %b value %h want 1 cafef00d", bus.ready,
               bus.MEM_R_value); end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 32'd1024, 32'hAAAA5555);
    for (int c = 0; c < 3; c++) tick();
    n_tests++; if (bus.sram_we_n !== 1'b0 || bus.sram_addr !== 18'd1) begin n_fail++;
      $display("FAIL mid_hi got we_n %b addr %0d want 0 1", bus.sram_we_n, bus.sram_addr); end
    rst = 1'b1;
    #1;
    n_tests++; if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin n_fail++;
      $display("FAIL mid_pins got we_n %b oe %b want 1 0", bus.sram_we_n, bus.sram_dq_oe); end
    n_tests++; if (bus.MEM_R_value !== 32'd0) begin n_fail++;
      $display("FAIL mid_rvalue got %h want 0", bus.MEM_R_value); end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    n_tests++; if (bus.ready !== 1'b1) begin n_fail++;
      $display("FAIL mid_ready got %b want 1", bus.ready); end
    tick();
    rst = 1'b0;
    tick();
    drive(1'b1, 1'b0, 32'd1028, 32'd0);
    n_tests++; if (bus.ready !== 1'b0) begin n_fail++;
      $display("FAIL post_rst_req got ready %b want 0", bus.ready); end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 16'h0000;
    test_reset();
    test_load();
    test_store();
    test_both();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
